// File: rtl/multicycle_alu.sv
// Registered-output ALU: seven single-cycle ops plus an N-cycle shift-add multiply.
// A valid/ready handshake is used on both the operand side and the result side.
module multicycle_alu #(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f,
  output logic         cout,
  output logic         v,
  output logic         z,
  output logic         busy
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);
  localparam logic [CW-1:0]  DONE = CW'(N);

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_NOR = 3'b101,
                         OP_SLT = 3'b110, OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state, state_d;
  logic [N-1:0]   f_d, mcand, mcand_d, b_eff;
  logic           cout_d, v_d, load, out_free, accept, add_c0;
  logic [N:0]     add_sum, step_sum;
  logic [2*N-1:0] prod, prod_d, prod_step, prod_fin;
  logic [CW-1:0]  cnt, cnt_d;

  assign out_free = !out_valid || out_ready;
  assign in_ready = rst_n && (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MUL);

  // SUB reuses the adder as a + ~b + 1; cin only reaches the adder for ADD.
  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign add_c0  = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? cin : 1'b0);
  assign add_sum = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, add_c0};

  // Multiplier sits in the low half of prod and shifts out as the product shifts in.
  assign step_sum  = {1'b0, prod[2*N-1:N]} + {1'b0, (prod[0] ? mcand : {N{1'b0}})};
  assign prod_step = {step_sum, prod[N-1:1]};
  assign prod_fin  = (cnt == DONE) ? prod : prod_step;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    load    = 1'b0;
    f_d     = f;
    cout_d  = cout;
    v_d     = v;
    prod_d  = prod;
    mcand_d = mcand;
    cnt_d   = cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          load   = 1'b1;
          cout_d = 1'b0;
          v_d    = 1'b0;
          case (op)
            OP_ADD, OP_SUB: begin
              f_d    = add_sum[N-1:0];
              cout_d = add_sum[N];
              v_d    = (a[N-1] ^ b_eff[N-1] ^ add_sum[N-1]) ^ add_sum[N];
            end
            OP_AND: f_d = a & b;
            OP_OR:  f_d = a | b;
            OP_XOR: f_d = a ^ b;
            OP_NOR: f_d = ~(a | b);
            OP_SLT: f_d = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL: begin
              if (MUL_EN) begin
                load    = 1'b0;
                state_d = MUL;
                prod_d  = {{N{1'b0}}, b};
                mcand_d = a;
                cnt_d   = '0;
              end else begin
                f_d = '0;
              end
            end
            default: f_d = '0;
          endcase
        end
      end

      MUL: begin
        if (cnt != DONE) begin
          prod_d = prod_step;
          cnt_d  = cnt + 1'b1;
        end
        // A finished product waits here (cnt == DONE) until the result slot is free.
        if ((cnt >= LAST) && out_free) begin
          load    = 1'b1;
          f_d     = prod_fin[N-1:0];
          cout_d  = |prod_fin[2*N-1:N];
          v_d     = 1'b0;
          state_d = IDLE;
          prod_d  = '0;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      f         <= '0;
      cout      <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= state_d;
      f      <= f_d;
      cout   <= cout_d;
      v      <= v_d;
      prod   <= prod_d;
      mcand  <= mcand_d;
      cnt    <= cnt_d;
      if (load) begin
        out_valid <= 1'b1;
        z         <= (f_d == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter N, default 32, datapath width in bits; legal range 4..64.
REQ-002 SHALL have parameter MUL_EN, default 1; 1 enables multi-cycle multiply, 0 makes op 111 a single-cycle op returning zero.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand/op presented.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port op  input  3  operation select.
REQ-008 SHALL have port cin  input  1  carry-in, used by ADD only.
REQ-009 SHALL have ports a, b  input  N  operands.
REQ-010 SHALL have port out_valid  output  1  result registers hold a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port f  output  N  result.
REQ-013 SHALL have ports cout, v, z  output  1 each  carry, signed overflow, zero flags.
REQ-014 SHALL have port busy  output  1  multiply in progress.

Function
REQ-015 SHALL perform ops: 000 ADD a+b+cin; 001 SUB a-b (computed as a+~b+1, cin ignored); 010 AND; 011 OR; 100 XOR; 101 NOR; 110 SLT (f=1 if signed a<b, else 0); 111 MUL (low N bits of unsigned a*b).
REQ-016 SHALL accept an operation on a rising edge when in_valid and in_ready are both 1; other in_valid cycles are ignored.
REQ-017 SHALL drive in_ready = 1 only in state IDLE and only when out_valid=0 or out_ready=1 that cycle.
REQ-018 SHALL use FSM states IDLE, MUL; IDLE->MUL on accepted op 111 with MUL_EN=1; MUL->IDLE after its final iteration; all other accepted ops stay in IDLE.
REQ-019 SHALL give single-cycle ops latency 1: f and flags registered, out_valid=1 on the edge after acceptance.
REQ-020 SHALL compute MUL by shift-add, one multiplicand bit per cycle, N cycles in MUL; out_valid rises on the edge ending the Nth MUL cycle (latency N+1 from acceptance edge, counted inclusive of that edge).
REQ-021 SHALL hold busy=1 for exactly the cycles in MUL state.
REQ-022 SHALL hold f, cout, v, z stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid on an edge with out_ready=1 unless a new result is loaded on the same edge, in which case out_valid stays 1 (back-to-back single-cycle throughput of 1 per clock).
REQ-024 SHALL set cout for ADD/SUB to carry out of bit N-1 (SUB: 1 = no borrow); v = carry into bit N-1 XOR carry out of bit N-1.
REQ-025 SHALL set cout=0, v=0 for AND, OR, XOR, NOR, SLT.
REQ-026 SHALL set, for MUL, cout=1 if any bit of the 2N-bit product above bit N-1 is 1, else 0; v=0.
REQ-027 SHALL set z=1 exactly when registered f is all zeros, for every op.
REQ-028 SHALL ignore op, a, b, cin, in_valid while busy=1.
REQ-029 SHALL tolerate out_ready toggling during MUL; completion waits in MUL-final result load only if out_valid=0 or out_ready=1, otherwise holds the final product internally and stays in MUL with busy=1 until the slot frees.

Reset
REQ-030 SHALL, while rst_n=0, force: state IDLE, out_valid=0, busy=0, f=0, cout=0, v=0, z=0, MUL iteration counter and partial product=0; in_ready=0.
REQ-031 SHALL abort an in-progress MUL on reset assertion with no result ever delivered for it.
REQ-032 SHALL resume normal acceptance on the first rising edge after rst_n deasserts (in_ready=1 that cycle).

Verification
REQ-033 SHALL cover ADD N=32: a=7FFFFFFF, b=1, cin=0 -> f=80000000, v=1, cout=0, z=0, out_valid one cycle later.
REQ-034 SHALL cover SUB: a=5, b=5 -> f=0, z=1, cout=1, v=0; a=0, b=1 -> f=FFFFFFFF, cout=0.
REQ-035 SHALL cover MUL: a=00010000, b=00010000 -> f=0, z=1, cout=1, busy high 32 cycles, out_valid at cycle 33.
REQ-036 SHALL cover backpressure: out_ready=0 for 5 cycles after ADD result -> f/flags constant, in_ready=0; releasing out_ready with new in_valid -> next result next edge, no bubble.
REQ-037 SHALL cover reset mid-MUL: rst_n low at MUL cycle 10 -> busy=0, out_valid=0 immediately; no MUL result after release.
REQ-038 SHALL cover SLT and N=8 build: a=80, b=01 -> f=01, cout=0, v=0.
